// File: rtl/bp_dma_concentrator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_dma_concentrator_pkg
// Description : Shared types and helpers for the DMA concentrator. Provides
//               the link packet layout, the default channel-ID width and an
//               index-width helper used for channel IDs, FIFO pointers and
//               beat counters.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_dma_concentrator_pkg;

    localparam int BP_DMA_ADDR_WIDTH = 28;
    localparam int BP_DMA_NUM_CH     = 4;

    // Width needed to index n items; never narrower than one bit.
    function automatic int bp_dma_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BP_DMA_CH_ID_WIDTH = bp_dma_idx_width(BP_DMA_NUM_CH);

    // Packet layout: the MSB selects write (1) or read (0).
    typedef struct packed {
        logic                         write_not_read;
        logic [BP_DMA_ADDR_WIDTH-1:0] addr;
    } bp_dma_pkt_s;

endpackage
`default_nettype wire

// File: rtl/bp_dma_order_tracker.sv
`default_nettype none
// ============================================================================
// Module      : bp_dma_order_tracker
// Description : FIFO of channel IDs plus a beat counter. The head entry names
//               the channel owning the current data burst; the entry pops on
//               the last beat of that burst.
// Ports       : push_v_i/push_id_i - enqueue a channel ID (ignored when full)
//               full_o             - no room for another ID
//               head_id_o/head_v_o - registered head entry and non-empty flag
//               beat_v_i           - one data beat of the head burst completed
//               pop_o              - this beat is the last of the burst
// Revision    : 1.0 - initial release
// ============================================================================
module bp_dma_order_tracker
    import bp_dma_concentrator_pkg::*;
#(
    parameter int els_p       = 8,
    parameter int id_width_p  = 2,
    parameter int burst_len_p = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  push_v_i,
    input  logic [id_width_p-1:0] push_id_i,
    output logic                  full_o,
    output logic [id_width_p-1:0] head_id_o,
    output logic                  head_v_o,
    input  logic                  beat_v_i,
    output logic                  pop_o
);

    localparam int PTR_W = bp_dma_idx_width(els_p);
    localparam int CNT_W = bp_dma_idx_width(burst_len_p);
    localparam int OCC_W = $clog2(els_p + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(els_p - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(burst_len_p - 1);

    logic [id_width_p-1:0] mem_q [els_p];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic [CNT_W-1:0]      beat_q, beat_d;
    logic                  push, beat, pop;

    assign full_o    = (occ_q == OCC_W'(els_p));
    assign head_v_o  = (occ_q != '0);
    assign head_id_o = mem_q[rd_ptr_q];

    // Full blocks a push even when the head pops in the same cycle.
    assign push  = push_v_i & ~full_o;
    assign beat  = beat_v_i & head_v_o;
    assign pop   = beat & (beat_q == LAST_BEAT);
    assign pop_o = pop;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        beat_d   = beat_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!push && pop) begin
            occ_d = occ_q - OCC_W'(1);
        end
        if (beat) begin
            beat_d = pop ? '0 : beat_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            beat_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            beat_q   <= beat_d;
        end
    end

    // ID storage needs no reset: entries are only read while occupancy > 0.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_id_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bp_dma_concentrator.sv
`default_nettype none
// ============================================================================
// Module      : bp_dma_concentrator
// Description : Merges num_dma_p DMA channels onto one in-order off-chip DMA
//               link. Packets are round-robin arbitrated; ID FIFOs record the
//               grant order so returning read data and outgoing write data
//               are steered to/from the right channel.
// Ports       : ch_pkt_*   - per-channel packet request/accept
//               ch_wdata_* - per-channel write data toward the link
//               ch_rdata_* - per-channel read data from the link
//               pkt_*, wdata_*, rdata_* - single off-chip link
//               err_o      - sticky: read data seen with no read outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module bp_dma_concentrator
    import bp_dma_concentrator_pkg::*;
#(
    parameter int num_dma_p    = 4,
    parameter int addr_width_p = 28,
    parameter int data_width_p = 64,
    parameter int burst_len_p  = 4,
    parameter int rd_els_p     = 8,
    parameter int wr_els_p     = 4,
    parameter int pkt_width_p  = 1 + addr_width_p
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_dma_p*pkt_width_p-1:0]  ch_pkt_i,
    input  logic [num_dma_p-1:0]              ch_pkt_v_i,
    output logic [num_dma_p-1:0]              ch_pkt_ready_and_o,
    input  logic [num_dma_p*data_width_p-1:0] ch_wdata_i,
    input  logic [num_dma_p-1:0]              ch_wdata_v_i,
    output logic [num_dma_p-1:0]              ch_wdata_ready_and_o,
    output logic [num_dma_p*data_width_p-1:0] ch_rdata_o,
    output logic [num_dma_p-1:0]              ch_rdata_v_o,
    input  logic [num_dma_p-1:0]              ch_rdata_ready_and_i,
    output logic [pkt_width_p-1:0]            pkt_o,
    output logic                              pkt_v_o,
    input  logic                              pkt_ready_and_i,
    output logic [data_width_p-1:0]           wdata_o,
    output logic                              wdata_v_o,
    input  logic                              wdata_ready_and_i,
    input  logic [data_width_p-1:0]           rdata_i,
    input  logic                              rdata_v_i,
    output logic                              rdata_ready_and_o,
    output logic                              err_o
);

    localparam int ID_W = bp_dma_idx_width(num_dma_p);
    localparam logic [ID_W-1:0] LAST_CH = ID_W'(num_dma_p - 1);

    logic [pkt_width_p-1:0]  pkt_arr   [num_dma_p];
    logic [data_width_p-1:0] wdata_arr [num_dma_p];
    logic [num_dma_p-1:0]    elig;
    logic [ID_W-1:0]         rr_q, rr_d, win_id;
    logic                    win_v, win_wnr, pkt_hs;
    logic                    rd_full, rd_head_v, rd_pop, rd_beat;
    logic                    wr_full, wr_head_v, wr_pop, wr_beat;
    logic [ID_W-1:0]         rd_head, wr_head;
    logic                    err_q, err_d;
    logic                    unused_pop;

    // A channel competes only if the FIFO its packet would enter has room.
    for (genvar i = 0; i < num_dma_p; i++) begin : g_ch
        assign pkt_arr[i]   = ch_pkt_i[i*pkt_width_p +: pkt_width_p];
        assign wdata_arr[i] = ch_wdata_i[i*data_width_p +: data_width_p];
        assign elig[i]      = ch_pkt_v_i[i] &
                              (pkt_arr[i][pkt_width_p-1] ? ~wr_full : ~rd_full);
    end

    // Round-robin: first eligible channel at or after the pointer.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] cand;
        win_v  = 1'b0;
        win_id = rr_q;
        idx    = 0;
        cand   = '0;
        for (int k = 0; k < num_dma_p; k++) begin
            idx  = (int'(rr_q) + k) % num_dma_p;
            cand = ID_W'(idx);
            if (!win_v && elig[cand]) begin
                win_v  = 1'b1;
                win_id = cand;
            end
        end
    end

    assign win_wnr            = pkt_arr[win_id][pkt_width_p-1];
    assign pkt_o              = pkt_arr[win_id];
    assign pkt_v_o            = reset_n_i & win_v;
    assign pkt_hs             = pkt_v_o & pkt_ready_and_i;
    assign ch_pkt_ready_and_o = pkt_hs ? (num_dma_p'(1) << win_id) : '0;

    always_comb begin
        rr_d  = rr_q;
        if (pkt_hs) begin
            rr_d = (win_id == LAST_CH) ? '0 : win_id + ID_W'(1);
        end
        err_d = err_q | (rdata_v_i & ~rd_head_v);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

    bp_dma_order_tracker #(
        .els_p       (rd_els_p),
        .id_width_p  (ID_W),
        .burst_len_p (burst_len_p)
    ) u_rd_order (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_v_i  (pkt_hs & ~win_wnr),
        .push_id_i (win_id),
        .full_o    (rd_full),
        .head_id_o (rd_head),
        .head_v_o  (rd_head_v),
        .beat_v_i  (rd_beat),
        .pop_o     (rd_pop)
    );

    bp_dma_order_tracker #(
        .els_p       (wr_els_p),
        .id_width_p  (ID_W),
        .burst_len_p (burst_len_p)
    ) u_wr_order (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_v_i  (pkt_hs & win_wnr),
        .push_id_i (win_id),
        .full_o    (wr_full),
        .head_id_o (wr_head),
        .head_v_o  (wr_head_v),
        .beat_v_i  (wr_beat),
        .pop_o     (wr_pop)
    );

    // Burst completion is tracked internally; the pop strobes are informational.
    assign unused_pop = rd_pop | wr_pop;

    // Write path: only the channel at the head of the write order is connected.
    assign wdata_o              = wr_head_v ? wdata_arr[wr_head] : '0;
    assign wdata_v_o            = reset_n_i & wr_head_v & ch_wdata_v_i[wr_head];
    assign ch_wdata_ready_and_o = (reset_n_i & wr_head_v & wdata_ready_and_i)
                                  ? (num_dma_p'(1) << wr_head) : '0;
    assign wr_beat              = wdata_v_o & wdata_ready_and_i;

    // Read path: data is broadcast, valid/ready steered by the read order head.
    // With nothing outstanding the link is stalled rather than dropped.
    assign ch_rdata_o        = {num_dma_p{rdata_i}};
    assign ch_rdata_v_o      = (reset_n_i & rd_head_v & rdata_v_i)
                               ? (num_dma_p'(1) << rd_head) : '0;
    assign rdata_ready_and_o = reset_n_i & rd_head_v & ch_rdata_ready_and_i[rd_head];
    assign rd_beat           = rdata_v_i & rdata_ready_and_o;

endmodule
`default_nettype wire
